// File: rtl/mac_seq_ctrl.sv
// mac_seq_ctrl: job sequencer for a non-pipelined 16-bit MAC.
// Takes a job (mode, pair count), configures the MAC, streams operand pairs
// from a valid/ready source, drains, reads the result and reports done/err.
module mac_seq_ctrl #(
    parameter int LEN_W     = 8,
    parameter int DRAIN_CYC = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             job_mode,
    input  logic [LEN_W-1:0] job_len,
    output logic             busy,
    output logic             done,
    output logic [15:0]      result,
    output logic             err,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [15:0]      op_a,
    input  logic [15:0]      op_b,
    output logic             mac_enable,
    output logic             mac_valid,
    output logic             mac_read,
    output logic             mac_cfg,
    output logic             mac_mode,
    output logic [15:0]      mac_in_a,
    output logic [15:0]      mac_in_b,
    input  logic [15:0]      mac_out,
    input  logic             mac_error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CFG,
        S_STREAM,
        S_DRAIN,
        S_READ
    } state_t;

    localparam int            DW         = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
    localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYC - 1);

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   count_q, count_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   count_inc;
    logic [DW-1:0]      drain_q, drain_d;
    logic [15:0]        result_q, result_d;
    logic               err_q, err_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;
    logic               mac_enable_q, mac_enable_d;
    logic               mac_valid_q, mac_valid_d;
    logic               mac_read_q, mac_read_d;
    logic               mac_cfg_q, mac_cfg_d;
    logic               mac_mode_q, mac_mode_d;
    logic [15:0]        mac_in_a_q, mac_in_a_d;
    logic [15:0]        mac_in_b_q, mac_in_b_d;
    logic               hs;

    // Abort must drop ready in the same cycle so no pair is taken on the way out.
    assign op_ready  = (state_q == S_STREAM) && (count_q < len_q) && !abort;
    assign hs        = op_valid && op_ready;
    assign count_inc = count_q + LEN_W'(1);

    assign busy       = busy_q;
    assign done       = done_q;
    assign result     = result_q;
    assign err        = err_q;
    assign mac_enable = mac_enable_q;
    assign mac_valid  = mac_valid_q;
    assign mac_read   = mac_read_q;
    assign mac_cfg    = mac_cfg_q;
    assign mac_mode   = mac_mode_q;
    assign mac_in_a   = mac_in_a_q;
    assign mac_in_b   = mac_in_b_q;

    // Next-state and next-output logic; strobes are decoded from the next state
    // so every MAC control output comes straight from a flop.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        len_d       = len_q;
        drain_d     = drain_q;
        result_d    = result_q;
        err_d       = err_q;
        done_d      = 1'b0;
        mac_valid_d = 1'b0;
        mac_mode_d  = mac_mode_q;
        mac_in_a_d  = mac_in_a_q;
        mac_in_b_d  = mac_in_b_q;

        if (state_q == S_STREAM || state_q == S_DRAIN || state_q == S_READ) begin
            err_d = err_q | mac_error;
        end

        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    err_d = 1'b0;
                    if (job_len == '0) begin
                        // Empty job completes without touching the MAC.
                        done_d   = 1'b1;
                        result_d = 16'h0000;
                    end else begin
                        state_d    = S_CFG;
                        len_d      = job_len;
                        count_d    = '0;
                        mac_mode_d = job_mode;
                    end
                end
            end
            S_CFG: begin
                state_d = S_STREAM;
            end
            S_STREAM: begin
                if (hs) begin
                    count_d     = count_inc;
                    mac_valid_d = 1'b1;
                    mac_in_a_d  = op_a;
                    mac_in_b_d  = op_b;
                    if (count_inc == len_q) begin
                        state_d = S_DRAIN;
                        drain_d = '0;
                    end
                end
            end
            S_DRAIN: begin
                if (drain_q == DRAIN_LAST) begin
                    state_d = S_READ;
                end else begin
                    drain_d = drain_q + DW'(1);
                end
            end
            S_READ: begin
                state_d  = S_IDLE;
                done_d   = 1'b1;
                result_d = mac_out;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort leaves result/err as they were and parks the MAC interface at zero.
        if (abort && state_q != S_IDLE) begin
            state_d     = S_IDLE;
            count_d     = count_q;
            done_d      = 1'b0;
            result_d    = result_q;
            err_d       = err_q;
            mac_valid_d = 1'b0;
            mac_mode_d  = 1'b0;
            mac_in_a_d  = 16'h0000;
            mac_in_b_d  = 16'h0000;
        end

        busy_d       = (state_d != S_IDLE);
        mac_cfg_d    = (state_d == S_CFG);
        mac_read_d   = (state_d == S_READ);
        mac_enable_d = (state_d == S_STREAM) || (state_d == S_DRAIN) || (state_d == S_READ);
    end

    // State and registered outputs; reset clears everything including result/err.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q      <= S_IDLE;
            count_q      <= '0;
            len_q        <= '0;
            drain_q      <= '0;
            result_q     <= 16'h0000;
            err_q        <= 1'b0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
            mac_enable_q <= 1'b0;
            mac_valid_q  <= 1'b0;
            mac_read_q   <= 1'b0;
            mac_cfg_q    <= 1'b0;
            mac_mode_q   <= 1'b0;
            mac_in_a_q   <= 16'h0000;
            mac_in_b_q   <= 16'h0000;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            len_q        <= len_d;
            drain_q      <= drain_d;
            result_q     <= result_d;
            err_q        <= err_d;
            done_q       <= done_d;
            busy_q       <= busy_d;
            mac_enable_q <= mac_enable_d;
            mac_valid_q  <= mac_valid_d;
            mac_read_q   <= mac_read_d;
            mac_cfg_q    <= mac_cfg_d;
            mac_mode_q   <= mac_mode_d;
            mac_in_a_q   <= mac_in_a_d;
            mac_in_b_q   <= mac_in_b_d;
        end
    end

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Testbench for mac_seq_ctrl: table of chained jobs plus abort/reset sequences.
module tb_mac_seq_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic        job_mode;
    logic [7:0]  job_len;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic        err;
    logic        op_valid;
    logic        op_ready;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic        mac_enable;
    logic        mac_valid;
    logic        mac_read;
    logic        mac_cfg;
    logic        mac_mode;
    logic [15:0] mac_in_a;
    logic [15:0] mac_in_b;
    logic [15:0] mac_out;
    logic        mac_error;

    mac_seq_ctrl #(.LEN_W(8), .DRAIN_CYC(1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .job_mode   (job_mode),
        .job_len    (job_len),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .err        (err),
        .op_valid   (op_valid),
        .op_ready   (op_ready),
        .op_a       (op_a),
        .op_b       (op_b),
        .mac_enable (mac_enable),
        .mac_valid  (mac_valid),
        .mac_read   (mac_read),
        .mac_cfg    (mac_cfg),
        .mac_mode   (mac_mode),
        .mac_in_a   (mac_in_a),
        .mac_in_b   (mac_in_b),
        .mac_out    (mac_out),
        .mac_error  (mac_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        mode;
        logic [7:0]  len;
        logic [31:0] stall;     // bit c: op_valid low in job cycle c
        logic [15:0] mo;        // mac_out = mo ^ cycle
        int          err_at;    // cycle with mac_error pulse, -1 none
        int          poke_at;   // cycle with a stray start, -1 none
        int          exp_done;
        logic [31:0] exp_vmask; // cycles with mac_valid high
        int          exp_read;
        logic        exp_err;
    } vec_t;

    typedef struct {
        int          done_cyc;
        int          read_cyc;
        int          cfg_cyc;
        logic        cfg_mode;
        logic        cfg_en;
        logic        mode_at_done;
        logic [31:0] vmask;
        logic [15:0] result;
        logic        err;
        logic        busy_seen;
        logic        en_seen;
        logic [31:0] last_in;
        bit          seen_valid;
    } job_res_t;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] sb[$];
    job_res_t    jr;
    vec_t        vec[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic next_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_jr();
        jr.done_cyc   = -1;
        jr.read_cyc   = -1;
        jr.cfg_cyc    = -1;
        jr.cfg_mode   = 1'b0;
        jr.cfg_en     = 1'b0;
        jr.mode_at_done = 1'b0;
        jr.vmask      = '0;
        jr.result     = '0;
        jr.err        = 1'b0;
        jr.busy_seen  = 1'b0;
        jr.en_seen    = 1'b0;
        jr.last_in    = '0;
        jr.seen_valid = 1'b0;
    endtask

    // Sample one cycle on the falling edge and run the operand scoreboard.
    task automatic sample_cycle(input int c);
        logic [31:0] exp;
        @(negedge clk);
        if (op_valid && op_ready) sb.push_back({op_a, op_b});
        if (mac_valid) begin
            if (c >= 0 && c < 32) jr.vmask[c] = 1'b1;
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL mac_valid_unexpected: got mac_valid=1 at cycle %0d, expected no pending pair", c);
            end else begin
                exp = sb.pop_front();
                check($sformatf("mac_operands_c%0d", c), {mac_in_a, mac_in_b}, exp);
            end
            jr.last_in    = {mac_in_a, mac_in_b};
            jr.seen_valid = 1'b1;
        end else if (mac_enable && jr.seen_valid) begin
            check($sformatf("operand_hold_c%0d", c), {mac_in_a, mac_in_b}, jr.last_in);
        end
        if (mac_cfg) begin
            jr.cfg_cyc  = c;
            jr.cfg_mode = mac_mode;
            jr.cfg_en   = mac_enable;
        end
        if (mac_read) jr.read_cyc = c;
        if (busy) jr.busy_seen = 1'b1;
        if (mac_enable) jr.en_seen = 1'b1;
    endtask

    // Run one job: start at cycle 0, drive operands/stalls, stop at done.
    task automatic run_job(input vec_t v, input bit cont_in, input bit cont_out);
        clear_jr();
        if (!cont_in) next_edge();
        start     = 1'b1;
        abort     = 1'b0;
        job_mode  = v.mode;
        job_len   = v.len;
        op_valid  = 1'b0;
        mac_error = 1'b0;
        mac_out   = v.mo;
        sample_cycle(0);
        for (int c = 1; c < 40; c++) begin
            next_edge();
            start    = (c == v.poke_at);
            job_mode = (c == v.poke_at) ? ~v.mode : v.mode;
            job_len  = (c == v.poke_at) ? 8'd1 : v.len;
            if (done) begin
                jr.done_cyc     = c;
                jr.result       = result;
                jr.err          = err;
                jr.mode_at_done = mac_mode;
                start     = 1'b0;
                op_valid  = 1'b0;
                mac_error = 1'b0;
                if (!cont_out) sample_cycle(c);
                return;
            end
            op_valid  = !v.stall[c];
            op_a      = 16'($urandom);
            op_b      = 16'($urandom);
            mac_error = (c == v.err_at);
            mac_out   = v.mo ^ 16'(c);
            sample_cycle(c);
        end
    endtask

    // Run a job and compare everything it produced against the vector.
    task automatic apply(input vec_t v, input int id, input bit cont_in, input bit cont_out);
        logic [15:0] exp_res;
        run_job(v, cont_in, cont_out);
        exp_res = (v.len == 0) ? 16'h0000 : (v.mo ^ 16'(v.exp_read));
        check($sformatf("v%0d_done_cycle", id), 32'(jr.done_cyc), 32'(v.exp_done));
        check($sformatf("v%0d_result", id), 32'(jr.result), 32'(exp_res));
        check($sformatf("v%0d_err", id), 32'(jr.err), 32'(v.exp_err));
        check($sformatf("v%0d_valid_cycles", id), jr.vmask, v.exp_vmask);
        check($sformatf("v%0d_read_cycle", id), 32'(jr.read_cyc), 32'(v.exp_read));
        check($sformatf("v%0d_cfg_cycle", id), 32'(jr.cfg_cyc), (v.len == 0) ? 32'hFFFF_FFFF : 32'd1);
        check($sformatf("v%0d_busy_seen", id), 32'(jr.busy_seen), 32'(v.len != 0));
        check($sformatf("v%0d_enable_seen", id), 32'(jr.en_seen), 32'(v.len != 0));
        if (v.len != 0) begin
            check($sformatf("v%0d_cfg_mode", id), 32'(jr.cfg_mode), 32'(v.mode));
            check($sformatf("v%0d_cfg_enable_low", id), 32'(jr.cfg_en), 32'd0);
            check($sformatf("v%0d_mode_held", id), 32'(jr.mode_at_done), 32'(v.mode));
        end
    endtask

    initial begin
        logic [15:0] prev_res;
        int          done_cnt;
        vec_t        vb;

        rst_n = 1'b1; start = 1'b0; abort = 1'b0; job_mode = 1'b0; job_len = '0;
        op_valid = 1'b0; op_a = '0; op_b = '0; mac_out = '0; mac_error = 1'b0;
        clear_jr();

        vec[0] = '{1'b1, 8'd3,  32'h0000_0000, 16'hA5C3, -1, -1,  7, 32'h0000_0038,  6, 1'b0};
        vec[1] = '{1'b0, 8'd4,  32'h0000_0008, 16'h1234, -1, -1,  9, 32'h0000_00E8,  8, 1'b0};
        vec[2] = '{1'b1, 8'd1,  32'h0000_0000, 16'hFFFF, -1, -1,  5, 32'h0000_0008,  4, 1'b0};
        vec[3] = '{1'b0, 8'd6,  32'h0000_0024, 16'h0F0F, -1, -1, 12, 32'h0000_07B0, 11, 1'b0};
        vec[4] = '{1'b1, 8'd2,  32'h0000_0000, 16'h8001,  4,  3,  6, 32'h0000_0018,  5, 1'b1};
        vec[5] = '{1'b1, 8'd0,  32'h0000_0000, 16'h5555, -1, -1,  1, 32'h0000_0000, -1, 1'b0};
        vec[6] = '{1'b0, 8'd20, 32'h0000_0000, 16'h7E57, -1, -1, 24, 32'h007F_FFF8, 23, 1'b0};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_outputs", {busy, done, err, op_ready, mac_enable, mac_valid, mac_read, mac_cfg, mac_mode},
              32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_operands", {mac_in_a, mac_in_b}, 32'd0);
        rst_n = 1'b0;
        @(negedge clk);
        check("post_rst_idle", {busy, done, mac_enable}, 32'd0);

        // Chained table: each job starts in the cycle the previous one signals done
        for (int i = 0; i < 7; i++) begin
            apply(vec[i], i, i > 0, i < 6);
        end
        prev_res = vec[6].mo ^ 16'(vec[6].exp_read);

        // Abort in the second STREAM cycle of a 5-pair job
        clear_jr();
        next_edge();
        start = 1'b1; job_mode = 1'b0; job_len = 8'd5; op_valid = 1'b1;
        op_a = 16'($urandom); op_b = 16'($urandom);
        sample_cycle(0);
        next_edge(); start = 1'b0; sample_cycle(1);
        next_edge(); op_a = 16'($urandom); op_b = 16'($urandom); sample_cycle(2);
        next_edge(); abort = 1'b1; op_a = 16'($urandom); op_b = 16'($urandom);
        #1;
        check("abort_ready_drop", 32'(op_ready), 32'd0);
        sample_cycle(3);
        next_edge(); abort = 1'b0;
        check("abort_strobes", {busy, mac_enable, mac_valid, mac_read, mac_cfg, mac_mode}, 32'd0);
        done_cnt = 0;
        for (int c = 4; c < 10; c++) begin
            if (c > 4) next_edge();
            if (done) done_cnt++;
            sample_cycle(c);
        end
        check("abort_no_done", 32'(done_cnt), 32'd0);
        check("abort_result_kept", 32'(result), 32'(prev_res));
        check("abort_sb_empty", 32'(sb.size()), 32'd0);
        op_valid = 1'b0;

        vb = '{1'b1, 8'd2, 32'h0, 16'h3C3C, -1, -1, 6, 32'h0000_0018, 5, 1'b0};
        apply(vb, 7, 1'b0, 1'b0);

        // Asynchronous reset between edges in the middle of a stream
        clear_jr();
        next_edge();
        start = 1'b1; job_mode = 1'b1; job_len = 8'd4; op_valid = 1'b1;
        op_a = 16'($urandom); op_b = 16'($urandom);
        sample_cycle(0);
        next_edge(); start = 1'b0; sample_cycle(1);
        for (int c = 2; c < 4; c++) begin
            next_edge(); op_a = 16'($urandom); op_b = 16'($urandom); sample_cycle(c);
        end
        next_edge();
        #2;
        rst_n = 1'b1;
        #1;
        check("midrst_outputs", {busy, done, err, op_ready, mac_enable, mac_valid, mac_read, mac_cfg, mac_mode},
              32'd0);
        check("midrst_result", 32'(result), 32'd0);
        check("midrst_operands", {mac_in_a, mac_in_b}, 32'd0);
        sb.delete();
        op_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;

        vb = '{1'b0, 8'd2, 32'h0, 16'hBEEF, -1, -1, 6, 32'h0000_0018, 5, 1'b0};
        apply(vb, 8, 1'b0, 1'b0);
        check("final_sb_empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mac_seq_ctrl.md
# mac_seq_ctrl

Job sequencer for the non-pipelined 16-bit MAC. It accepts a job request (mode, operand-pair count) and configures the MAC mode with a `cfg` pulse while `enable` is low. It then streams operand pairs from a valid/ready source into the MAC, waits a drain interval, issues the `read` strobe, and returns the 16-bit result with a done pulse. It sits between the operand buffer/host logic and the MAC, and owns every MAC control strobe.

## Interface
- `LEN_W`, 8: width of the job length and pair counter.
- `DRAIN_CYC`, 1: cycles (≥1) from the first DRAIN cycle to the READ cycle.

- `clk` in 1: clock, rising edge.
- `rst_n` in 1: reset. Asynchronous, active-high: 1 clears all state, despite the name suffix.
- `start` in 1: job request; sampled only in IDLE.
- `abort` in 1: cancel the current job.
- `job_mode` in 1: 1 = fp16, 0 = int8; captured with `start`.
- `job_len` in LEN_W: number of operand pairs; captured with `start`.
- `busy` out 1: high in CFG, STREAM, DRAIN and READ.
- `done` out 1: one-cycle pulse when a job completes.
- `result` out 16: last job result; held until the next completion.
- `err` out 1: sticky MAC error for the last job; valid with `done`.
- `op_valid` in 1, `op_ready` out 1, `op_a` in 16, `op_b` in 16: operand stream.
- `mac_enable`, `mac_valid`, `mac_read`, `mac_cfg`, `mac_mode` out 1 each: MAC control strobes.
- `mac_in_a`, `mac_in_b` out 16: MAC operands.
- `mac_out` in 16: MAC result.
- `mac_error` in 1: MAC error flag.

## Operation
- States: IDLE, CFG, STREAM, DRAIN, READ. All outputs are registered except `op_ready`.
- IDLE, `start`=1, `job_len`≠0: latch mode and length, clear `err` and the pair counter, go to CFG.
- IDLE, `start`=1, `job_len`=0: no MAC activity. The next cycle gives `done`=1, `result`=0 and `err`=0.
- CFG (1 cycle): `mac_cfg`=1, `mac_enable`=0, `mac_mode`=latched mode, then go to STREAM. `mac_mode` holds until the next CFG.
- STREAM: `mac_enable`=1. `op_ready` = (state==STREAM && count<len && !abort).
  - Handshake = `op_valid`&&`op_ready`.
  - On a handshake, the next cycle drives `mac_valid`=1 and `mac_in_a`/`mac_in_b` = `op_a`/`op_b`, and count increments.
  - Without a handshake, the next cycle drives `mac_valid`=0 and the operands hold.
  - The handshake that makes count==len moves the state to DRAIN.
- DRAIN: `mac_enable`=1 for DRAIN_CYC cycles. `mac_valid` is high only in the first DRAIN cycle (the last pair).
- READ (1 cycle): `mac_enable`=1, `mac_read`=1, `mac_valid`=0. Capture `mac_out` into `result` at the cycle end, then go to IDLE with `done`=1 for one cycle.
- `err` |= `mac_error`, sampled in every STREAM, DRAIN and READ cycle.
- `start` outside IDLE is ignored. `start` and `abort` together in IDLE: abort wins and the job is not accepted.
- `abort` in any non-IDLE state: next cycle IDLE, all `mac_*` strobes 0, no `done`. `result` and `err` are unchanged, and un-accepted operands are not consumed.
- Counter width is LEN_W. count never exceeds len, so there is no wrap.

## Timing
- Reset values: every output is 0, state is IDLE, and `mac_mode`=0.
- Reset mid-job: immediate return to IDLE with all outputs 0. `result` and `err` are also cleared.
- `start` is sampled at cycle 0. Cycle 1 is CFG and cycle 2 is the first STREAM cycle (`op_ready` can be high).
- Last handshake at cycle k:
  - `mac_valid`=1 at k+1 (first DRAIN cycle).
  - READ at k+DRAIN_CYC+1.
  - `done` and the new `result` at k+DRAIN_CYC+2.
- Back-to-back jobs: `start` is accepted in the same cycle that `done`=1.
- Gap-free stream: with `op_valid` held high, N pairs reach the MAC on N consecutive cycles (3..N+2).
- Total latency with no stalls: N+DRAIN_CYC+3 cycles from `start` to `done`.

## Test plan
- **fp16 job, N=3, DRAIN_CYC=1, no stalls, start at cycle 0:** CFG at 1 with `mac_mode`=1; `mac_valid` at 3,4,5 with the matching operands; READ at 6; `done` at 7 with `result` equal to `mac_out` sampled at 6.
- **int8 job, N=4, `op_valid` low at cycle 3:** `op_ready` stays high; 4 pulses, with `mac_valid` low at cycle 4 only; `done` at cycle 9 (one cycle later than the unstalled case); `mac_mode`=0.
- **`job_len`=0:** no `mac_cfg`, `mac_enable` or `mac_valid`; `done`=1 at cycle 1 with `result`=0x0000.
- **`abort` at the second STREAM cycle of an N=5 job:** `op_ready` drops the same cycle; all `mac_*` are 0 the next cycle; no `done`; previous `result` retained; a new `start` is then accepted normally.
- **`mac_error` pulsed for one cycle during DRAIN:** `err`=1 with `done`; `err` clears at the next `start`; `start` during `busy` is ignored, with no change to count or mode.
- **`rst_n`=1 asserted mid-STREAM (asynchronous, between edges):** all outputs 0 immediately; IDLE after release; a subsequent N=2 job completes correctly.
